// File: rtl/reg_file_sb.sv
// Register file with per-entry busy scoreboard and a sequential clear engine.
// Define REG_FILE_SB_BYPASS_EN to forward same-cycle write data to read ports.
module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] R_Addr_A,
    input  logic [ADDR_W-1:0] R_Addr_B,
    output logic [DATA_W-1:0] R_Data_A,
    output logic [DATA_W-1:0] R_Data_B,
    output logic              Busy_A,
    output logic              Busy_B,
    input  logic              Write_Reg,
    input  logic [ADDR_W-1:0] W_Addr,
    input  logic [DATA_W-1:0] W_Data,
    input  logic              Busy_Set,
    input  logic [ADDR_W-1:0] Busy_Addr,
    input  logic              Clr_Req,
    output logic              Clr_Busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;

    logic w_clr;
    logic w_we;
    logic w_set;

    assign w_clr    = (r_state == CLEAR);
    assign w_we     = Write_Reg && !w_clr && (W_Addr != '0);
    assign w_set    = Busy_Set && !w_clr && (Busy_Addr != '0);
    assign Clr_Busy = w_clr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy  <= '0;
            r_cnt   <= '0;
            r_state <= IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_we) begin
                        r_mem[W_Addr]  <= W_Data;
                        r_busy[W_Addr] <= 1'b0;
                    end
                    // set after write so a same-address issue keeps it pending
                    if (w_set) begin
                        r_busy[Busy_Addr] <= 1'b1;
                    end
                    if (Clr_Req) begin
                        r_state <= CLEAR;
                        r_cnt   <= ADDR_W'(1);
                    end
                end
                CLEAR: begin
                    r_mem[r_cnt]  <= '0;
                    r_busy[r_cnt] <= 1'b0;
                    if (r_cnt == LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        R_Data_A = (R_Addr_A == '0) ? '0 : r_mem[R_Addr_A];
        R_Data_B = (R_Addr_B == '0) ? '0 : r_mem[R_Addr_B];
        Busy_A   = (R_Addr_A == '0) ? 1'b0 : r_busy[R_Addr_A];
        Busy_B   = (R_Addr_B == '0) ? 1'b0 : r_busy[R_Addr_B];
`ifdef REG_FILE_SB_BYPASS_EN
        if (w_we && (W_Addr == R_Addr_A)) begin
            R_Data_A = W_Data;
            Busy_A   = Busy_Set && (Busy_Addr == R_Addr_A);
        end
        if (w_we && (W_Addr == R_Addr_B)) begin
            R_Data_B = W_Data;
            Busy_B   = Busy_Set && (Busy_Addr == R_Addr_B);
        end
`endif
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: vector table, clear/reset/bypass sequences, and
// randomized traffic against a queue-based reference model.
module tb_reg_file_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] ra, rb;
    logic [DW-1:0] rda, rdb;
    logic          bza, bzb;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          bs;
    logic [AW-1:0] ba;
    logic          clr;
    logic          clr_busy;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .R_Addr_A(ra), .R_Addr_B(rb),
        .R_Data_A(rda), .R_Data_B(rdb),
        .Busy_A(bza), .Busy_B(bzb),
        .Write_Reg(we), .W_Addr(wa), .W_Data(wd),
        .Busy_Set(bs), .Busy_Addr(ba),
        .Clr_Req(clr), .Clr_Busy(clr_busy)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: array contents, pending flags, and the list of
    // addresses still waiting to be wiped by an in-flight clear.
    logic [DW-1:0] m_mem [DEPTH];
    logic          m_busy [DEPTH];
    int            pend_clr [$];

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          bs;
        logic [AW-1:0] ba;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        logic          eba;
        logic          ebb;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void exp_read(input logic [AW-1:0] a,
                                     output logic [DW-1:0] d,
                                     output logic b);
        d = m_mem[a];
        b = m_busy[a];
        if (a == 0) begin
            d = '0;
            b = 1'b0;
        end
`ifdef REG_FILE_SB_BYPASS_EN
        if (we && pend_clr.size() == 0 && wa != 0 && wa == a) begin
            d = wd;
            b = bs && (ba == a);
        end
`endif
    endfunction

    task automatic check_now();
        logic [DW-1:0] d;
        logic          b;
        if (chk_en) begin
            exp_read(ra, d, b);
            chk("rdata_a", rda, d);
            chk("busy_a", {31'b0, bza}, {31'b0, b});
            exp_read(rb, d, b);
            chk("rdata_b", rdb, d);
            chk("busy_b", {31'b0, bzb}, {31'b0, b});
            chk("clr_busy", {31'b0, clr_busy}, {31'b0, pend_clr.size() != 0});
        end
    endtask

    task automatic edge_update();
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 1'b0;
            end
            pend_clr.delete();
        end else if (pend_clr.size() != 0) begin
            int a;
            a = pend_clr.pop_front();
            m_mem[a]  = '0;
            m_busy[a] = 1'b0;
        end else begin
            if (we && wa != 0) begin
                m_mem[wa]  = wd;
                m_busy[wa] = 1'b0;
            end
            if (bs && ba != 0) m_busy[ba] = 1'b1;
            if (clr) begin
                for (int i = 1; i < DEPTH; i++) pend_clr.push_back(i);
            end
        end
        #1;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_now();
        edge_update();
    endtask

    task automatic quiet();
        reset = 1'b1;
        we    = 1'b0;
        bs    = 1'b0;
        clr   = 1'b0;
        wa    = '0;
        wd    = '0;
        ba    = '0;
    endtask

    task automatic fill_all();
        for (int a = 1; a < DEPTH; a++) begin
            quiet();
            we = 1'b1;
            wa = AW'(a);
            wd = $urandom | 32'h1;
            ra = AW'($urandom);
            rb = AW'($urandom);
            cycle();
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            quiet();
            ra = AW'(a);
            rb = AW'(DEPTH - 1 - a);
            @(negedge clk);
            check_now();
            chk(tag, rda, '0);
            edge_update();
        end
    endtask

    initial begin
        int n_busy;
        logic [DW-1:0] exp_d;

        tbl[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd31, 32'h0,        32'h0,        1'b0, 1'b0};
        tbl[1]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd31, 32'h0,        32'h0,        1'b0, 1'b0};
        tbl[2]  = '{1'b1, 5'd0, 32'h1,        1'b0, 5'd0, 5'd5, 5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd0, 5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd0,  32'h0,        32'h0,        1'b1, 1'b0};
        tbl[5]  = '{1'b1, 5'd7, 32'h55,       1'b0, 5'd0, 5'd5, 5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd0,  32'h55,       32'h0,        1'b0, 1'b0};
        tbl[7]  = '{1'b1, 5'd7, 32'h66,       1'b1, 5'd7, 5'd5, 5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd7,  32'h66,       32'h66,       1'b1, 1'b1};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 5'd7,  32'h0,        32'h66,       1'b0, 1'b1};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0};

        quiet();
        ra    = '0;
        rb    = '0;
        reset = 1'b0;
        cycle();
        chk_en = 1'b1;

        for (int i = 0; i < 11; i++) begin
            quiet();
            we = tbl[i].we;
            wa = tbl[i].wa;
            wd = tbl[i].wd;
            bs = tbl[i].bs;
            ba = tbl[i].ba;
            ra = tbl[i].ra;
            rb = tbl[i].rb;
            @(negedge clk);
            check_now();
            chk($sformatf("vec%0d_a", i), rda, tbl[i].ea);
            chk($sformatf("vec%0d_b", i), rdb, tbl[i].eb);
            chk($sformatf("vec%0d_ba", i), {31'b0, bza}, {31'b0, tbl[i].eba});
            chk($sformatf("vec%0d_bb", i), {31'b0, bzb}, {31'b0, tbl[i].ebb});
            chk($sformatf("vec%0d_cb", i), {31'b0, clr_busy}, 32'h0);
            edge_update();
        end

        quiet();
        we = 1'b1; wa = 5'd3; wd = 32'h12345678; ra = 5'd0; rb = 5'd0;
        cycle();
        quiet();
        we = 1'b1; wa = 5'd3; wd = 32'hA5A5A5A5; ra = 5'd3; rb = 5'd3;
        @(negedge clk);
        check_now();
`ifdef REG_FILE_SB_BYPASS_EN
        exp_d = 32'hA5A5A5A5;
`else
        exp_d = 32'h12345678;
`endif
        chk("bypass_same_cycle", rda, exp_d);
        edge_update();
        quiet();
        ra = 5'd3;
        @(negedge clk);
        check_now();
        chk("bypass_next_cycle", rda, 32'hA5A5A5A5);
        edge_update();

        fill_all();
        quiet();
        clr = 1'b1;
        cycle();
        n_busy = 0;
        for (int k = 0; k < 36; k++) begin
            quiet();
            clr = (k < 31);
            if (k == 15) begin
                we = 1'b1; wa = 5'd30; wd = 32'hBAD0BAD0;
                bs = 1'b1; ba = 5'd31;
            end
            ra = AW'($urandom);
            rb = AW'($urandom);
            @(negedge clk);
            check_now();
            if (clr_busy) n_busy++;
            edge_update();
        end
        chk("clear_cycles", n_busy, 31);
        check_all_zero("after_clear");

        fill_all();
        quiet();
        clr = 1'b1;
        cycle();
        for (int k = 0; k < 10; k++) begin
            quiet();
            reset = (k != 9);
            ra = AW'($urandom);
            rb = AW'($urandom);
            cycle();
        end
        quiet();
        @(negedge clk);
        check_now();
        chk("reset_mid_clear_busy", {31'b0, clr_busy}, 32'h0);
        edge_update();
        check_all_zero("after_reset_mid_clear");

        for (int k = 0; k < 600; k++) begin
            quiet();
            reset = ($urandom_range(0, 149) != 0);
            we    = $urandom_range(0, 1) == 1;
            wa    = AW'($urandom);
            wd    = $urandom;
            bs    = $urandom_range(0, 3) == 0;
            ba    = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
            clr   = $urandom_range(0, 79) == 0;
            ra    = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
            rb    = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
